// File: rtl/multi7_scan.sv
// Multiplexed N-digit 7-segment scan driver with refresh prescaler, per-slot dead time,
// PWM brightness, decimal points, leading-zero blanking and frame-synchronous double buffering.
module multi7_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1024,
  parameter int PWM_BITS = 4,
  parameter int DEAD     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DIGITS*4-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  output logic                  o_ready,
  input  logic [PWM_BITS-1:0]   i_brightness,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_segments_drive,
  output logic                  o_dp_drive,
  output logic [DIGITS-1:0]     o_displays_neg,
  output logic                  o_frame
);

  localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W  = $clog2(DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] DEAD_C    = SLOT_W'(DEAD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan counters and brightness latch
  logic [SLOT_W-1:0]   slot_cnt_q;
  logic [IDX_W-1:0]    digit_idx_q;
  logic [PWM_BITS-1:0] bright_q;

  // Double buffer: pending is filled by the handshake, active feeds the display
  logic [DIGITS*4-1:0] active_digits_q, pend_digits_q;
  logic [DIGITS-1:0]   active_dp_q, pend_dp_q;
  logic                pend_valid_q;

  // Registered outputs
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   disp_q;
  logic                frame_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic                slot_wrap;
  logic                boundary;
  logic                load_accept;
  logic                disp_on;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [DIGITS-1:0]   disp_d;

  assign slot_wrap   = (slot_cnt_q == SLOT_LAST);
  assign boundary    = slot_wrap && (digit_idx_q == IDX_LAST);
  assign load_accept = i_load && !pend_valid_q;
  assign disp_on     = (slot_cnt_q >= DEAD_C) && (slot_cnt_q[PWM_BITS-1:0] < bright_q);

  // A digit is a leading zero when it and every more-significant active nibble is zero.
  always_comb begin
    logic zero_above;
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above && (active_digits_q[k*4 +: 4] == 4'h0);
      blank_vec[k] = i_blank_lz && zero_above;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    disp_d    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx_q == IDX_W'(k)) begin
        cur_nib   = active_digits_q[k*4 +: 4];
        cur_dp    = active_dp_q[k];
        cur_blank = blank_vec[k];
        disp_d[k] = !disp_on;
      end
    end
    seg_d = (disp_on && !cur_blank) ? seg_decode(cur_nib) : 7'h00;
    dp_d  = disp_on && cur_dp;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_cnt_q      <= '0;
      digit_idx_q     <= '0;
      bright_q        <= '0;
      active_digits_q <= '0;
      active_dp_q     <= '0;
      pend_digits_q   <= '0;
      pend_dp_q       <= '0;
      pend_valid_q    <= 1'b0;
      seg_q           <= '0;
      dp_q            <= 1'b0;
      disp_q          <= '1;
      frame_q         <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt_q  <= '0;
        digit_idx_q <= (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
      end else begin
        slot_cnt_q  <= slot_cnt_q + 1'b1;
      end

      if (slot_cnt_q == '0) bright_q <= i_brightness;

      // Transfer and acceptance are mutually exclusive: acceptance needs pending empty.
      if (boundary && pend_valid_q) begin
        active_digits_q <= pend_digits_q;
        active_dp_q     <= pend_dp_q;
        pend_valid_q    <= 1'b0;
      end else if (load_accept) begin
        pend_digits_q   <= i_digits;
        pend_dp_q       <= i_dp;
        pend_valid_q    <= 1'b1;
      end

      seg_q   <= seg_d;
      dp_q    <= dp_d;
      disp_q  <= disp_d;
      frame_q <= boundary;
    end
  end

  assign o_ready          = !pend_valid_q;
  assign o_segments_drive = seg_q;
  assign o_dp_drive       = dp_q;
  assign o_displays_neg   = disp_q;
  assign o_frame          = frame_q;

endmodule

// File: tb/tb_multi7_scan.sv
// Self-checking bench for multi7_scan: a cycle-count based model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_multi7_scan;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 32;
  localparam int PWM_BITS = 4;
  localparam int DEAD     = 2;
  localparam int FRAME    = PRESCALE * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [3:0]  bright = '0;
  logic        blz = 1'b0;
  logic        ready;
  logic [6:0]  segs;
  logic        dp_drv;
  logic [3:0]  disp;
  logic        frame;

  multi7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS), .DEAD(DEAD)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_digits         (digits),
    .i_dp             (dp),
    .i_load           (load),
    .o_ready          (ready),
    .i_brightness     (bright),
    .i_blank_lz       (blz),
    .o_segments_drive (segs),
    .o_dp_drive       (dp_drv),
    .o_displays_neg   (disp),
    .o_frame          (frame)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: n counts clock edges since reset release; counters derive from it.
  int          m_n = 0;
  int          m_bright = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_adp = '0, m_pdp = '0;
  bit          m_pv = 1'b0;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0;
  logic [3:0]  e_disp = 4'hF;
  logic        e_frame = 1'b0;
  logic        e_ready = 1'b1;
  bit          chk_en = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_n = 0; m_bright = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
      e_seg = '0; e_dp = 1'b0; e_disp = 4'hF; e_frame = 1'b0; e_ready = 1'b1;
    end else begin
      int slot, dig;
      bit on, bnd, blanked, acc, xfer;
      logic [3:0] nib;
      slot    = m_n % PRESCALE;
      dig     = (m_n / PRESCALE) % DIGITS;
      bnd     = (m_n % FRAME) == FRAME - 1;
      on      = (slot >= DEAD) && ((slot % (1 << PWM_BITS)) < m_bright);
      nib     = 4'(m_act >> (4 * dig));
      blanked = (dig != 0) && blz && ((m_act >> (4 * dig)) == 0);
      e_disp  = on ? ~(4'b1 << dig) : 4'hF;
      e_seg   = (on && !blanked) ? seg_tab[nib] : 7'h00;
      e_dp    = on && m_adp[dig];
      e_frame = bnd;
      acc     = load && !m_pv;
      xfer    = bnd && m_pv;
      if (slot == 0) m_bright = int'(bright);
      if (xfer) begin m_act = m_pend; m_adp = m_pdp; m_pv = 1'b0; end
      if (acc)  begin m_pend = digits; m_pdp = dp; m_pv = 1'b1; end
      e_ready = !m_pv;
      m_n++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_segs",  32'(segs),   32'(e_seg));
      check("model_dp",    32'(dp_drv), 32'(e_dp));
      check("model_disp",  32'(disp),   32'(e_disp));
      check("model_frame", 32'(frame),  32'(e_frame));
      check("model_ready", 32'(ready),  32'(e_ready));
    end
  end

  // pos = negedges elapsed since the last observed o_frame pulse.
  int pos = 0;

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < 400);
    check("frame_seen", 32'(frame), 32'd1);
    pos = 0;
  endtask

  // Move to the negedge where outputs reflect slot index k of the frame (k = digit*32 + slot).
  task automatic goto(input int k);
    if (k + 1 > pos) repeat (k + 1 - pos) @(negedge clk);
    pos = k + 1;
  endtask

  initial begin
    int n, cnt;
    bright = 4'd15;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // "0000" after reset
    wait_frame(n);
    goto(5);  check("zero_d0_seg", 32'(segs), 32'h3F); check("zero_d0_en", 32'(disp), 32'hE);
    goto(37); check("zero_d1_seg", 32'(segs), 32'h3F); check("zero_d1_en", 32'(disp), 32'hD);

    // Load 'h1234
    digits = 16'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("ready_low_after_load", 32'(ready), 32'd0);
    wait_frame(n);
    check("ready_after_frame", 32'(ready), 32'd1);
    goto(0);   check("dead_slot0", 32'(disp), 32'hF); check("frame_one_cycle", 32'(frame), 32'd0);
    goto(1);   check("dead_slot1", 32'(disp), 32'hF);
    goto(2);   check("d0_seg", 32'(segs), 32'h66); check("d0_en", 32'(disp), 32'hE);
    goto(15);  check("pwm_off_15", 32'(disp), 32'hF);
    goto(37);  check("d1_seg", 32'(segs), 32'h4F); check("d1_en", 32'(disp), 32'hD);
    goto(69);  check("d2_seg", 32'(segs), 32'h5B); check("d2_en", 32'(disp), 32'hB);
    goto(101); check("d3_seg", 32'(segs), 32'h06); check("d3_en", 32'(disp), 32'h7);

    // Brightness 4
    bright = 4'd4;
    wait_frame(n);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin goto(k); if (disp != 4'hF) cnt++; end
    check("bright4_period0_on", 32'(cnt), 32'd2);
    for (int k = 16; k < 32; k++) begin goto(k); if (disp != 4'hF) cnt++; end
    check("bright4_slot_on", 32'(cnt), 32'd6);
    goto(40);  bright = 4'd15;
    goto(44);  check("bright_midslot_held", 32'(disp), 32'hF);
    goto(76);  check("bright_next_slot", 32'(disp), 32'hB);
    bright = 4'd0;
    wait_frame(n);
    cnt = 0;
    for (int k = 0; k < FRAME; k++) begin goto(k); if (disp != 4'hF) cnt++; end
    check("bright0_dark", 32'(cnt), 32'd0);

    // Leading-zero blanking
    bright = 4'd15; blz = 1'b1; digits = 16'h0050; dp = 4'b0100; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(n);
    goto(5);   check("lz_d0", 32'(segs), 32'h3F);
    goto(37);  check("lz_d1", 32'(segs), 32'h6D);
    goto(69);  check("lz_d2_seg", 32'(segs), 32'h00); check("lz_d2_dp", 32'(dp_drv), 32'd1);
    check("lz_d2_en", 32'(disp), 32'hB);
    goto(101); check("lz_d3_seg", 32'(segs), 32'h00); check("lz_d3_en", 32'(disp), 32'h7);
    digits = 16'h0000; dp = 4'b0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(n);
    goto(5);   check("lz0_d0", 32'(segs), 32'h3F);
    goto(37);  check("lz0_d1", 32'(segs), 32'h00); check("lz0_d1_en", 32'(disp), 32'hD);

    // Second load while not ready is dropped
    blz = 1'b0; digits = 16'hAAAA; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("ready_low_aaaa", 32'(ready), 32'd0);
    digits = 16'hBBBB; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_frame(n);
    goto(5);   check("aaaa_d0", 32'(segs), 32'h77);
    goto(101); check("aaaa_d3", 32'(segs), 32'h77);
    wait_frame(n);
    goto(5);   check("bbbb_dropped", 32'(segs), 32'h77); check("ready_idle", 32'(ready), 32'd1);

    // Load on the boundary cycle itself waits a full frame
    goto(126);
    digits = 16'h5555; load = 1'b1;
    @(negedge clk); load = 1'b0;
    check("boundary_frame", 32'(frame), 32'd1);
    check("boundary_ready_low", 32'(ready), 32'd0);
    pos = 0;
    goto(5);   check("boundary_old_value", 32'(segs), 32'h77);
    wait_frame(n);
    check("frame_period_a", 32'(n + 6), 32'd128);
    goto(5);   check("boundary_new_value", 32'(segs), 32'h6D);

    // Frame cadence over three frames
    wait_frame(n);
    for (int f = 0; f < 3; f++) begin
      wait_frame(n);
      check("frame_period", 32'(n), 32'd128);
    end

    // Reset mid-frame with a load pending
    digits = 16'h9999; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_disp", 32'(disp), 32'hF);
    check("rst_segs", 32'(segs), 32'h00);
    check("rst_dp", 32'(dp_drv), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_frame", 32'(frame), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_frame(n);
    goto(5);  check("post_rst_d0", 32'(segs), 32'h3F); check("post_rst_en0", 32'(disp), 32'hE);
    goto(69); check("post_rst_d2", 32'(segs), 32'h3F); check("post_rst_en2", 32'(disp), 32'hB);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
